// File: rtl/layer2_ctrl_if.sv
// Layer-2 controller bus: convolution result stream in, result-memory write port out.
`timescale 1ns/1ps
interface layer2_ctrl_if;
    // Stream handshake: a beat transfers on every rising clk edge where
    // conv_valid && conv_ready are both high. The producer holds conv_data
    // stable while conv_valid is high; conv_ready never depends on conv_valid.
    logic              conv_valid;
    logic signed [7:0] conv_data;
    logic              conv_ready;

    // Result-memory write port: one write per cycle where store is high.
    logic              store;
    logic [3:0]        out_c;
    logic [7:0]        w_addr;
    logic signed [7:0] bias;
    logic signed [7:0] value;

    // Controller side.
    modport master (
        input  conv_valid, conv_data,
        output conv_ready, store, out_c, w_addr, bias, value
    );

    // Environment side (convolution engine plus result memory).
    modport slave (
        output conv_valid, conv_data,
        input  conv_ready, store, out_c, w_addr, bias, value
    );
endinterface

// File: rtl/layer2_ctrl.sv
// Layer-2 controller: collects OC x PIX convolution results in channel-major
// order, writes each one (with its channel bias) to the result memory one
// cycle after acceptance, then runs a pooling phase guarded by a timeout.
`timescale 1ns/1ps
module layer2_ctrl #(
    parameter int PIX          = 196,
    parameter int OC           = 16,
    parameter int POOL_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    layer2_ctrl_if.master     bus,
    output logic [3:0]        bias_addr,
    input  logic signed [7:0] bias_in,
    output logic              cout_done,
    output logic              pool,
    input  logic              pool_done_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        fsm_state
);

    localparam int PW = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int CW = (OC > 1) ? $clog2(OC) : 1;
    localparam int TW = $clog2(POOL_TIMEOUT + 1);

    localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(OC - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(POOL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STORE   = 3'd1,
        S_FLUSH   = 3'd2,
        S_POOL    = 3'd3,
        S_WAITCLR = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] ch;
    logic [PW-1:0] pix;
    logic [TW-1:0] tcnt;
    logic          hs;
    logic          last_item;
    logic          launch;
    logic          timeout_hit;

    // Only STORE accepts data, so valid beats elsewhere are simply dropped.
    assign bus.conv_ready = (state == S_STORE);
    assign hs             = bus.conv_valid && bus.conv_ready;
    assign last_item      = (ch == CH_LAST) && (pix == PIX_LAST);
    // The cycle being counted is the POOL_TIMEOUT-th POOL cycle; pool_done_in wins a tie.
    assign timeout_hit    = (state == S_POOL) && !pool_done_in && (tcnt == T_LAST);
    assign bias_addr      = 4'(ch);
    assign fsm_state      = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and level outputs derived from the current state.
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        busy     = 1'b1;
        pool     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    launch   = 1'b1;
                    state_nx = S_STORE;
                end
            end
            S_STORE: begin
                if (hs && last_item) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_nx = S_POOL;
            end
            S_POOL: begin
                pool = 1'b1;
                if (pool_done_in) begin
                    state_nx = S_WAITCLR;
                end else if (timeout_hit) begin
                    state_nx = S_FIN;
                end
            end
            S_WAITCLR: begin
                if (!pool_done_in) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Channel/pixel position and pool-cycle counter; the position saturates on the last item.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch   <= '0;
            pix  <= '0;
            tcnt <= '0;
        end else if (launch) begin
            ch   <= '0;
            pix  <= '0;
            tcnt <= '0;
        end else begin
            if (hs && !last_item) begin
                if (pix == PIX_LAST) begin
                    pix <= '0;
                    ch  <= ch + 1'b1;
                end else begin
                    pix <= pix + 1'b1;
                end
            end
            if (state == S_POOL) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Registered write port, channel-complete flag and sticky timeout error.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.store  <= 1'b0;
            bus.out_c  <= '0;
            bus.w_addr <= '0;
            bus.bias   <= '0;
            bus.value  <= '0;
            cout_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            bus.store <= hs;
            // FLUSH is the cycle of the final write, so this pulse lands right after it.
            cout_done <= (state == S_FLUSH);
            if (hs) begin
                bus.out_c  <= 4'(ch);
                bus.w_addr <= 8'(pix);
                bus.bias   <= bias_in;
                bus.value  <= bus.conv_data;
            end
            if (launch) begin
                err <= 1'b0;
            end else if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer2_ctrl.sv
// Bench for layer2_ctrl: directed vector table, then whole passes driven with
// random data checked cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_layer2_ctrl;
  localparam int PIX   = 196;
  localparam int OC    = 16;
  localparam int TOUT  = 4096;
  localparam int TOTAL = PIX * OC;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_FLUSH = 2, P_POOL = 3, P_WAITCLR = 4, P_FIN = 5;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic pool_done_in = 1'b0;
  logic [3:0] bias_addr;
  logic signed [7:0] bias_in;
  logic cout_done, pool, busy, done, err;
  logic [2:0] fsm_state;
  logic [7:0] rom [OC];

  layer2_ctrl_if bus();

  layer2_ctrl #(.PIX(PIX), .OC(OC), .POOL_TIMEOUT(TOUT)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus.master),
    .bias_addr(bias_addr),
    .bias_in(bias_in),
    .cout_done(cout_done),
    .pool(pool),
    .pool_done_in(pool_done_in),
    .busy(busy),
    .done(done),
    .err(err),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Bias ROM answers combinationally for the address the DUT presents.
  assign bias_in = rom[bias_addr];

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  int   m_phase = P_IDLE;
  int   m_taken = 0;
  int   m_pool_n = 0;
  bit   m_err = 0, m_cout = 0, m_valid = 0, m_zero = 0;
  logic [27:0] exp_q[$];
  int   cnt_store = 0, cnt_pool = 0, cnt_done = 0, cnt_cout = 0;

  always @(negedge clk) begin
    logic [6:0]  act_c, exp_c;
    logic [27:0] act_s, exp_s;
    bit          exp_store;
    if (bus.store === 1'b1) cnt_store++;
    if (pool === 1'b1) cnt_pool++;
    if (done === 1'b1) cnt_done++;
    if (cout_done === 1'b1) cnt_cout++;

    if (m_valid) begin
      exp_store = (exp_q.size() != 0);
      exp_c = {m_phase == P_COLLECT, m_phase != P_IDLE, m_phase == P_POOL, m_cout,
               m_phase == P_FIN, m_err, exp_store};
      act_c = {bus.conv_ready, busy, pool, cout_done, done, err, bus.store};
      chk("ctrl{ready,busy,pool,cout,done,err,store}", 32'(act_c), 32'(exp_c));
      act_s = {bus.out_c, bus.w_addr, bus.bias, bus.value};
      if (exp_store) begin
        exp_s = exp_q.pop_front();
        chk("store{out_c,w_addr,bias,value}", 32'(act_s), 32'(exp_s));
      end else if (m_zero) begin
        chk("reset_fields", {act_s, bias_addr}, 32'd0);
      end
    end

    // Advance the model over the inputs the DUT will sample at the next edge.
    if (rst === 1'b1) begin
      m_valid = 1;
      m_phase = P_IDLE;
      m_err   = 0;
      m_cout  = 0;
      m_zero  = 1;
      m_taken = 0;
      exp_q.delete();
    end else if (m_valid) begin
      m_zero = 0;
      m_cout = 0;
      case (m_phase)
        P_IDLE: if (start === 1'b1) begin
          m_phase  = P_COLLECT;
          m_taken  = 0;
          m_pool_n = 0;
          m_err    = 0;
        end
        P_COLLECT: if (bus.conv_valid === 1'b1) begin
          exp_q.push_back({4'(m_taken / PIX), 8'(m_taken % PIX), rom[m_taken / PIX], bus.conv_data});
          m_taken++;
          if (m_taken == TOTAL) m_phase = P_FLUSH;
        end
        P_FLUSH: begin
          m_phase = P_POOL;
          m_cout  = 1;
        end
        P_POOL: begin
          m_pool_n++;
          if (pool_done_in === 1'b1) m_phase = P_WAITCLR;
          else if (m_pool_n == TOUT) begin
            m_err   = 1;
            m_phase = P_FIN;
          end
        end
        P_WAITCLR: if (pool_done_in !== 1'b1) m_phase = P_FIN;
        P_FIN: m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic       rst;
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic [6:0] exp_ctrl;   // {conv_ready, busy, pool, cout_done, done, err, store}
    logic       chk_data;
    logic [7:0] exp_addr;
    logic [7:0] exp_val;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  // ---------------- driver ----------------
  // vmode 0: conv_valid held high, 1: toggling, 2: random. pool_len 0 never completes pooling.
  task automatic run_pass(input int vmode, input int pool_len, input int clr_hold, input bit poke);
    int n;
    bit tog;
    cnt_store = 0;
    cnt_pool  = 0;
    cnt_done  = 0;
    cnt_cout  = 0;
    start = 1'b1;
    bus.conv_valid = 1'b0;
    cyc();
    start = 1'b0;
    chk("start_clears{busy,err}", {30'd0, busy, err}, 32'd2);
    n = 0;
    tog = 1;
    while (pool !== 1'b1 && n < 30000) begin
      case (vmode)
        0: bus.conv_valid = 1'b1;
        1: begin
          bus.conv_valid = tog;
          tog = !tog;
        end
        default: bus.conv_valid = ($urandom_range(0, 1) == 1);
      endcase
      bus.conv_data = 8'($urandom);
      start = poke && ($urandom_range(0, 15) == 0);
      cyc();
      n++;
    end
    bus.conv_valid = 1'b0;
    start = 1'b0;
    chk("pool_reached", 32'(pool), 32'd1);
    if (pool === 1'b1) begin
      if (pool_len > 0) begin
        repeat (pool_len - 1) begin
          start = poke && ($urandom_range(0, 7) == 0);
          cyc();
        end
        start = 1'b0;
        pool_done_in = 1'b1;
        cyc();
        repeat (clr_hold) cyc();
        pool_done_in = 1'b0;
      end
      n = 0;
      while (busy !== 1'b0 && n < TOUT + 100) begin
        start = poke && ($urandom_range(0, 7) == 0);
        cyc();
        n++;
      end
      start = 1'b0;
      chk("idle_reached", 32'(busy), 32'd0);
    end
    chk("n_store", cnt_store, TOTAL);
    chk("n_cout_done", cnt_cout, 1);
    chk("n_done", cnt_done, 1);
    chk("n_pool_cycles", cnt_pool, (pool_len > 0) ? pool_len : TOUT);
  endtask

  // Watchdog for anything the bounded loops miss.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int k = 0; k < OC; k++) rom[k] = 8'(8'h10 + k);
    bus.conv_valid = 1'b0;
    bus.conv_data  = 8'd0;

    vec[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 7'b0000000, 1'b1, 8'd0, 8'h00};
    vec[1] = '{1'b0, 1'b0, 1'b1, 8'h5a, 7'b0000000, 1'b1, 8'd0, 8'h00};
    vec[2] = '{1'b0, 1'b1, 1'b1, 8'h33, 7'b1100000, 1'b0, 8'd0, 8'h00};
    vec[3] = '{1'b0, 1'b0, 1'b1, 8'h81, 7'b1100001, 1'b1, 8'd0, 8'h81};
    vec[4] = '{1'b0, 1'b0, 1'b0, 8'hff, 7'b1100000, 1'b0, 8'd0, 8'h00};
    vec[5] = '{1'b0, 1'b1, 1'b1, 8'h7e, 7'b1100001, 1'b1, 8'd1, 8'h7e};
    vec[6] = '{1'b0, 1'b0, 1'b1, 8'h02, 7'b1100001, 1'b1, 8'd2, 8'h02};
    vec[7] = '{1'b1, 1'b0, 1'b1, 8'h44, 7'b0000000, 1'b1, 8'd0, 8'h00};
    vec[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b0000000, 1'b1, 8'd0, 8'h00};

    rst = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < NV; i++) begin
      rst            = vec[i].rst;
      start          = vec[i].start;
      bus.conv_valid = vec[i].valid;
      bus.conv_data  = vec[i].data;
      cyc();
      chk($sformatf("vec%0d_ctrl", i),
          32'({bus.conv_ready, busy, pool, cout_done, done, err, bus.store}), 32'(vec[i].exp_ctrl));
      if (vec[i].chk_data)
        chk($sformatf("vec%0d_data", i), {16'd0, bus.w_addr, bus.value}, {16'd0, vec[i].exp_addr, vec[i].exp_val});
    end
    rst = 1'b0;
    start = 1'b0;
    bus.conv_valid = 1'b0;
    cyc();

    // Full pass, valid held high, pooling completes after 10 cycles, bias 0x10+ch.
    run_pass(0, 10, 1, 1'b0);
    // Toggling valid with stray start pulses.
    run_pass(1, 5, 0, 1'b1);
    // Pooling never completes: timeout path.
    run_pass(0, 0, 0, 1'b1);
    chk("err_sticky_after_timeout", 32'(err), 32'd1);

    // Reset in the middle of channel 5, pixel 100.
    start = 1'b1;
    cyc();
    start = 1'b0;
    bus.conv_valid = 1'b1;
    repeat (5 * PIX + 100) begin
      bus.conv_data = 8'($urandom);
      cyc();
    end
    chk("mid_position{bias_addr}", 32'(bias_addr), 32'd5);
    rst = 1'b1;
    cyc();
    chk("rst_mid_outputs",
        {bus.conv_ready, busy, pool, cout_done, done, err, bus.store,
         bus.out_c, bus.w_addr, bus.value, bias_addr}, 32'd0);
    rst = 1'b0;
    bus.conv_valid = 1'b0;
    cyc();

    // Fresh random bias ROM, random valid pattern, random pooling length.
    for (int k = 0; k < OC; k++) rom[k] = 8'($urandom);
    run_pass(2, $urandom_range(1, 20), $urandom_range(0, 3), 1'b1);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
